// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared ISA indices, opcodes, FSM states and branch helper for the softcore sequencer.
package control_unit_pkg;
  localparam int ISA_ADD = 0;
  localparam int ISA_ADDI = 1;
  localparam int ISA_SH = 2;
  localparam int ISA_SHI = 3;
  localparam int ISA_NOT = 4;
  localparam int ISA_AND = 5;
  localparam int ISA_OR = 6;
  localparam int ISA_XOR = 7;
  localparam int ISA_INSTRUCTION_COUNT = 8;
  localparam int ALU_FLAG_EQ = 0;
  localparam int ALU_FLAG_GT = 1;
  localparam int ALU_FLAG_COUNT = 2;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_ADDI, OP_SH, OP_SHI, OP_NOT, OP_AND, OP_OR,
    OP_XOR, OP_LD, OP_ST, OP_BEQ, OP_BGT, OP_JMP, OP_CMP, OP_HALT
  } opcode_t;
  typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  function automatic logic branch_taken(input opcode_t op, input logic [ALU_FLAG_COUNT-1:0] f);
    return op == OP_JMP || (op == OP_BEQ && f[ALU_FLAG_EQ]) || (op == OP_BGT && f[ALU_FLAG_GT]);
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction-memory fetch handshake plus the ALU control/flag bundle.
interface control_unit_if #(
  parameter int BIT_COUNT = 8,
  parameter int IMM_WIDTH = 4
);
  import control_unit_pkg::*;
  logic [BIT_COUNT-1:0] imem_addr;
  logic imem_req;
  logic imem_ack;
  logic [BIT_COUNT-1:0] imem_data;
  logic [ALU_FLAG_COUNT-1:0] alu_flags;
  logic [ISA_INSTRUCTION_COUNT-1:0] instruction_en;
  logic [IMM_WIDTH-1:0] imm;
  logic acc_we;
  logic reg_we;
  logic halted;
  modport master (
    output imem_addr, imem_req, instruction_en, imm, acc_we, reg_we, halted,
    input imem_ack, imem_data, alu_flags
  );
  modport slave (
    input imem_addr, imem_req, instruction_en, imm, acc_we, reg_we, halted,
    output imem_ack, imem_data, alu_flags
  );
endinterface

// File: rtl/control_unit_instr_decoder.sv
// instr_decoder: opcode to one-hot ALU enable and instruction class flags.
module instr_decoder
  import control_unit_pkg::*;
(
  input  opcode_t op,
  output logic [ISA_INSTRUCTION_COUNT-1:0] en,
  output logic is_alu,
  output logic is_ld,
  output logic is_st,
  output logic is_branch,
  output logic is_cmp,
  output logic is_halt
);
  always_comb begin
    is_alu = op inside {[OP_ADD:OP_XOR]};
    is_ld = op == OP_LD;
    is_st = op == OP_ST;
    is_branch = op inside {OP_BEQ, OP_BGT, OP_JMP};
    is_cmp = op == OP_CMP;
    is_halt = op == OP_HALT;
    en = '0;
    en[ISA_ADD] = op == OP_ADD;
    en[ISA_ADDI] = op == OP_ADDI;
    en[ISA_SH] = op == OP_SH;
    en[ISA_SHI] = op == OP_SHI;
    en[ISA_NOT] = op == OP_NOT;
    en[ISA_AND] = op == OP_AND;
    en[ISA_OR] = op == OP_OR;
    // CMP is an XOR whose result is discarded; only its flags matter
    en[ISA_XOR] = op == OP_XOR || op == OP_CMP;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/exec sequencer owning PC, IR and the captured ALU flags.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int BIT_COUNT = 8,
  parameter int IMM_WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  control_unit_if.master bus
);
  state_t state;
  logic [BIT_COUNT-1:0] pc, ir, pc_inc, pc_rel;
  logic [ALU_FLAG_COUNT-1:0] flags_q;
  opcode_t op;
  logic [ISA_INSTRUCTION_COUNT-1:0] dec_en;
  logic is_alu, is_ld, is_st, is_branch, is_cmp, is_halt;
  assign op = opcode_t'(ir[BIT_COUNT-1 -: $bits(opcode_t)]);
  assign pc_inc = pc + BIT_COUNT'(1);
  assign pc_rel = pc_inc + BIT_COUNT'($signed(ir[IMM_WIDTH-1:0]));
  assign bus.imem_addr = pc;
  assign bus.imm = ir[IMM_WIDTH-1:0];
  instr_decoder u_dec (
    .op(op), .en(dec_en), .is_alu(is_alu), .is_ld(is_ld), .is_st(is_st),
    .is_branch(is_branch), .is_cmp(is_cmp), .is_halt(is_halt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_RESET;
      pc <= '0;
      ir <= '0;
      flags_q <= '0;
      bus.imem_req <= 1'b0;
      bus.instruction_en <= '0;
      bus.acc_we <= 1'b0;
      bus.reg_we <= 1'b0;
      bus.halted <= 1'b0;
    end else begin
      bus.instruction_en <= '0;
      bus.acc_we <= 1'b0;
      bus.reg_we <= 1'b0;
      case (state)
        S_RESET: begin
          state <= S_FETCH;
          bus.imem_req <= 1'b1;
        end
        S_FETCH: if (bus.imem_ack) begin
          ir <= bus.imem_data;
          bus.imem_req <= 1'b0;
          state <= S_DECODE;
        end
        S_DECODE: begin
          bus.instruction_en <= dec_en;
          bus.acc_we <= is_alu | is_ld;
          bus.reg_we <= is_st;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_cmp || op == OP_XOR) flags_q <= bus.alu_flags;
          pc <= is_halt ? pc : (is_branch && branch_taken(op, flags_q)) ? pc_rel : pc_inc;
          bus.imem_req <= !is_halt;
          bus.halted <= is_halt;
          state <= is_halt ? S_HALT : S_FETCH;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scenarios plus randomized instruction stream checked against an ISA-level model.
module tb_control_unit;
  logic clk = 0;
  logic rst_n = 0;
  int tests = 0;
  int fails = 0;
  control_unit_if #(.BIT_COUNT(8), .IMM_WIDTH(4)) bus ();
  control_unit #(.BIT_COUNT(8), .IMM_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic ctrl_on();
    return (|bus.instruction_en) || bus.acc_we || bus.reg_we;
  endfunction

  // ISA-level expectations: ops 1..8 select ISA bits 0..7, CMP borrows the XOR bit
  function automatic logic [7:0] exp_en(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd8) return 8'd1 << (op - 4'd1);
    return op == 4'hE ? 8'h80 : 8'h00;
  endfunction

  function automatic logic [7:0] exp_pc(input logic [7:0] pc, input logic [7:0] ins, input logic [1:0] f);
    int off;
    logic take;
    off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
    take = ins[7:4] == 4'hD || (ins[7:4] == 4'hB && f[0]) || (ins[7:4] == 4'hC && f[1]);
    if (ins[7:4] == 4'hF) return pc;
    return 8'(int'(pc) + 1 + (take ? off : 0));
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    bus.imem_ack = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Serves one fetch and records what the DUT did; callers judge the observations.
  task automatic do_instr(input logic [7:0] ins, input int waits, input logic [1:0] fl, input logic hold,
                          output logic [7:0] addr, output logic stable, output logic [7:0] en,
                          output logic acc, output logic rw, output logic [3:0] im,
                          output logic stray, output int lat);
    int n;
    n = 0;
    stable = 1; stray = 0; addr = 'x; en = 'x; acc = 'x; rw = 'x; im = 'x; lat = -1;
    while (!bus.imem_req && n < 30) begin @(negedge clk); n++; end
    if (!bus.imem_req) return;
    addr = bus.imem_addr;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (!bus.imem_req || bus.imem_addr !== addr) stable = 0;
      if (ctrl_on()) stray = 1;
    end
    bus.imem_ack = 1;
    bus.imem_data = ins;
    @(negedge clk);
    if (bus.imem_req !== 1'b0 || ctrl_on()) stray = 1;
    bus.imem_ack = hold;
    bus.imem_data = ~ins;
    @(negedge clk);
    bus.imem_ack = 0;
    bus.alu_flags = fl;
    en = bus.instruction_en; acc = bus.acc_we; rw = bus.reg_we; im = bus.imm;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (ctrl_on()) stray = 1;
    end while (!bus.imem_req && n < 25);
    if (bus.imem_req) lat = waits + 2 + n;
  endtask

  task automatic test_reset();
    logic [7:0] a, e; logic s, ac, rw, st; logic [3:0] im; int lat;
    rst_n = 0;
    bus.imem_ack = 0;
    @(negedge clk);
    tests++;
    if ({bus.imem_req, bus.instruction_en, bus.acc_we, bus.reg_we, bus.halted, bus.imem_addr} !== 20'h0) begin
      fails++; $display("FAIL reset_idle: req=%b en=%h acc=%b reg=%b halt=%b addr=%h want all 0",
        bus.imem_req, bus.instruction_en, bus.acc_we, bus.reg_we, bus.halted, bus.imem_addr);
    end
    rst_n = 1;
    #1;
    tests++;
    if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_release_req: got %b want 0", bus.imem_req); end
    @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      fails++; $display("FAIL first_fetch: req=%b addr=%h want 1/00", bus.imem_req, bus.imem_addr);
    end
    do_instr(8'h00, 0, 2'b00, 0, a, s, e, ac, rw, im, st, lat);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin
      fails++; $display("FAIL fetch_pending: req=%b addr=%h want 1/01", bus.imem_req, bus.imem_addr);
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00) begin
      fails++; $display("FAIL async_reset_drop: req=%b addr=%h want 0/00", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    rst_n = 1;
    do_instr(8'h00, 0, 2'b00, 0, a, s, e, ac, rw, im, st, lat);
    tests++;
    if (a !== 8'h00) begin fails++; $display("FAIL restart_addr: got %h want 00", a); end
  endtask

  task automatic test_zero_wait();
    logic [7:0] a, e; logic s, ac, rw, st; logic [3:0] im; int lat;
    apply_reset();
    do_instr(8'h23, 0, 2'b00, 0, a, s, e, ac, rw, im, st, lat);
    tests++;
    if (a !== 8'h00 || e !== 8'h02 || ac !== 1'b1 || rw !== 1'b0 || im !== 4'h3) begin
      fails++; $display("FAIL addi_exec: addr=%h en=%h acc=%b reg=%b imm=%h want 00/02/1/0/3", a, e, ac, rw, im);
    end
    tests++;
    if (lat !== 3 || st !== 1'b0) begin fails++; $display("FAIL addi_timing: lat=%0d stray=%b want 3/0", lat, st); end
    tests++;
    if (bus.imem_addr !== 8'h01) begin fails++; $display("FAIL addi_next_pc: got %h want 01", bus.imem_addr); end
  endtask

  task automatic test_wait_states();
    logic [7:0] a, e; logic s, ac, rw, st; logic [3:0] im; int lat;
    apply_reset();
    do_instr(8'h23, 4, 2'b00, 0, a, s, e, ac, rw, im, st, lat);
    tests++;
    if (s !== 1'b1 || a !== 8'h00) begin fails++; $display("FAIL wait_stable: stable=%b addr=%h want 1/00", s, a); end
    tests++;
    if (lat !== 7 || e !== 8'h02 || ac !== 1'b1) begin
      fails++; $display("FAIL wait_timing: lat=%0d en=%h acc=%b want 7/02/1", lat, e, ac);
    end
  endtask

  task automatic test_branch();
    logic [7:0] ins [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE0, 8'hBE, 8'hE0, 8'hBE, 8'hE0, 8'hC3, 8'hB2, 8'hDF, 8'h00};
    logic [1:0] fl [13] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
    logic [7:0] want [13] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h04, 8'h05, 8'h06, 8'h07, 8'h0B, 8'h0C, 8'h0C};
    logic [7:0] a, e; logic s, ac, rw, st; logic [3:0] im; int lat;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      do_instr(ins[i], 0, fl[i], 0, a, s, e, ac, rw, im, st, lat);
      tests++;
      if (a !== want[i]) begin fails++; $display("FAIL branch_addr[%0d]: got %h want %h", i, a, want[i]); end
    end
  endtask

  task automatic test_jmp_wrap();
    logic [7:0] ins [10] = '{8'hD8, 8'h00, 8'hD7, 8'hD8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] want [10] = '{8'h00, 8'hF9, 8'hFA, 8'h02, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00};
    logic [7:0] a, e; logic s, ac, rw, st; logic [3:0] im; int lat;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      do_instr(ins[i], i % 2, 2'b00, 0, a, s, e, ac, rw, im, st, lat);
      tests++;
      if (a !== want[i]) begin fails++; $display("FAIL jmp_addr[%0d]: got %h want %h", i, a, want[i]); end
    end
  endtask

  task automatic test_halt();
    logic [7:0] a, e; logic s, ac, rw, st; logic [3:0] im; int lat;
    apply_reset();
    do_instr(8'h00, 0, 2'b00, 0, a, s, e, ac, rw, im, st, lat);
    do_instr(8'hF0, 0, 2'b00, 0, a, s, e, ac, rw, im, st, lat);
    tests++;
    if (lat !== -1 || st !== 1'b0 || e !== 8'h00 || ac !== 1'b0) begin
      fails++; $display("FAIL halt_quiet: lat=%0d stray=%b en=%h acc=%b want -1/0/00/0", lat, st, e, ac);
    end
    tests++;
    if (bus.halted !== 1'b1 || bus.imem_addr !== 8'h01) begin
      fails++; $display("FAIL halt_state: halted=%b addr=%h want 1/01", bus.halted, bus.imem_addr);
    end
    apply_reset();
    tests++;
    if (bus.halted !== 1'b0) begin fails++; $display("FAIL halt_cleared: got %b want 0", bus.halted); end
    do_instr(8'h00, 0, 2'b00, 0, a, s, e, ac, rw, im, st, lat);
    tests++;
    if (a !== 8'h00) begin fails++; $display("FAIL halt_resume: got %h want 00", a); end
  endtask

  task automatic test_random();
    logic [7:0] pc_m, ins, a, e; logic [1:0] fq, fl; logic s, ac, rw, st, hold; logic [3:0] im, op;
    int lat, waits;
    pc_m = 0; fq = 0;
    apply_reset();
    for (int k = 0; k < 80; k++) begin
      ins = 8'($urandom);
      if (ins[7:4] == 4'hF) ins[7:4] = 4'h0;
      op = ins[7:4];
      waits = $urandom_range(0, 3);
      fl = 2'($urandom);
      hold = 1'($urandom);
      do_instr(ins, waits, fl, hold, a, s, e, ac, rw, im, st, lat);
      tests++;
      if (a !== pc_m) begin fails++; $display("FAIL rnd_addr[%0d]: got %h want %h", k, a, pc_m); end
      tests++;
      if ({e, ac, rw, im} !== {exp_en(op), op >= 4'd1 && op <= 4'd9, op == 4'hA, ins[3:0]}) begin
        fails++; $display("FAIL rnd_ctrl[%0d] ins=%h: en=%h acc=%b reg=%b imm=%h want %h/%b/%b/%h", k, ins, e, ac, rw, im,
          exp_en(op), op >= 4'd1 && op <= 4'd9, op == 4'hA, ins[3:0]);
      end
      tests++;
      if (lat !== waits + 3 || s !== 1'b1 || st !== 1'b0) begin
        fails++; $display("FAIL rnd_timing[%0d]: lat=%0d stable=%b stray=%b want %0d/1/0", k, lat, s, st, waits + 3);
      end
      pc_m = exp_pc(pc_m, ins, fq);
      if (op == 4'h8 || op == 4'hE) fq = fl;
    end
  endtask

  initial begin
    bus.imem_ack = 0;
    bus.imem_data = 0;
    bus.alu_flags = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jmp_wrap();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Sequencer for the 8-bit softcore. It fetches 8-bit instructions from instruction memory over a req/ack handshake, decodes them into the one-hot `instruction_en` vector the ALU consumes, and drives accumulator/register write enables. It captures the ALU's comparison flags and uses them to resolve conditional branches, which makes it the producing end of the ALU's instruction-enable interface and the consuming end of its flags.

Parameters:
- BIT_COUNT, 8, datapath width. Also the PC width.
- IMM_WIDTH, 4, immediate/operand field width; `BIT_COUNT - IMM_WIDTH` is the opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  BIT_COUNT  fetch address (= PC).
- imem_req  out  1  fetch request.
- imem_ack  in  1  memory accepts the fetch; `imem_data` is valid in the same cycle.
- imem_data  in  BIT_COUNT  fetched instruction.
- alu_flags  in  `ALU_FLAG_COUNT`  ALU flags; bits indexed by `ALU_FLAG_EQ` and `ALU_FLAG_GT`.
- instruction_en  out  `ISA_INSTRUCTION_COUNT`  one-hot ALU operation select.
- imm  out  IMM_WIDTH  operand field `ir[3:0]` (immediate or register index).
- acc_we  out  1  write ALU result into `reg_acc`.
- reg_we  out  1  write `reg_acc` into register `imm` (ST).
- halted  out  1  high while in HALT.

Behaviour:
- Reset values (async, `rst_n` low): state=FETCH-entry (S_RESET), pc=0, ir=0, flags_q=0, imem_req=0, instruction_en=0, acc_we=0, reg_we=0, halted=0.
- Instruction format: `ir[7:4]` opcode, `ir[3:0]` imm/reg.
- Opcodes: 0 NOP, 1 ADD, 2 ADDI, 3 SH, 4 SHI, 5 NOT, 6 AND, 7 OR, 8 XOR, 9 LD (reg→acc through the ALU pass path), A ST, B BEQ, C BGT, D JMP, E CMP, F HALT. All 16 codes are legal.
- States: S_RESET → S_FETCH → S_DECODE → S_EXEC → S_FETCH; HALT → S_HALT.
  - S_RESET: one cycle after reset release, outputs idle.
  - S_FETCH: imem_req=1 and imem_addr=pc. On imem_ack: ir←imem_data and go to S_DECODE. Otherwise stay with req held and addr stable.
  - S_DECODE: one cycle; register the decoded controls.
  - S_EXEC: one cycle; outputs asserted as below; PC update; next state S_FETCH, or S_HALT for HALT.
  - S_HALT: absorbing state; halted=1; imem_req=0. Exit only via reset.
- Outputs in S_EXEC:
  - ALU ops 1–8: exactly one `instruction_en` bit at the matching `ISA_*` index, and acc_we=1.
  - LD: acc_we=1.
  - ST: reg_we=1.
  - CMP: `instruction_en[ISA_XOR]`=1 with acc_we=0.
  - Outside S_EXEC, `instruction_en`, acc_we and reg_we are all 0.
- Flags: flags_q←alu_flags at the end of S_EXEC for XOR and CMP only. All other instructions leave flags_q unchanged.
- PC update in S_EXEC, all arithmetic mod 2^BIT_COUNT (0xFF+1 wraps to 0x00):
  - Default: pc←pc+1.
  - BEQ taken when `flags_q[ALU_FLAG_EQ]`; BGT taken when `flags_q[ALU_FLAG_GT]`. Taken: pc←pc+1+sext(imm), imm a signed 4-bit value in −8..+7. Not taken: pc+1.
  - JMP: pc←pc+1+sext(imm) unconditionally.
  - HALT: pc unchanged.
- Timing:
  - Minimum 3 cycles per instruction with zero-wait-state memory (ack in the first FETCH cycle).
  - Each memory wait cycle adds one cycle.
- Boundaries:
  - imem_ack outside S_FETCH is ignored.
  - Reset asserted mid-fetch drops imem_req asynchronously; the fetch is abandoned and restarts from pc=0.
  - A branch whose flags were written by the immediately preceding instruction sees the updated flags_q, since no bypass is needed.
  - Branch offset −1 (imm=0xF) gives a self-loop.

Decomposition:
- Add to `param.vh`: opcode localparams (OP_NOP..OP_HALT), state encodings, and IMM_WIDTH. Reuse the existing `ISA_*` indices, `ISA_INSTRUCTION_COUNT`, `ALU_FLAG_*` and `ALU_FLAG_COUNT`.
- One combinational sub-module, `instr_decoder`: opcode → one-hot en, is_alu, is_ld, is_st, is_branch, is_cmp, is_halt.
- `control_unit` holds the FSM, PC, IR and flag register.

Test Plan:
- Reset: hold rst_n=0 mid-sequence → all outputs 0, pc=0. After release, first imem_req with imem_addr=0x00 two cycles later.
- Fetch 0x23 (ADDI 3) with ack on the first cycle → ir=0x23. Exactly two cycles later `instruction_en[ISA_ADDI]`=1 and acc_we=1 for one cycle. Next fetch at 0x01.
- Ack delayed 4 cycles → imem_req and imem_addr stay stable throughout. Instruction completes 4 cycles later than the zero-wait case.
- CMP (0xE0) with alu_flags EQ=1, then BEQ 0xBE at pc=0x05 → next fetch at 0x04. Repeat with EQ=0 → next fetch at 0x06.
- JMP 0xD7 at pc=0xFA → next fetch at 0x02 (wrap). Fetching 0x00 at pc=0xFF → next fetch at 0x00.
- HALT 0xF0 → halted=1, no further imem_req for 20 cycles. Assert then release rst_n → halted=0 and fetch resumes at 0x00.
